// File: rtl/alu_pkg.sv
// Types and constants shared by the Hack-style ALU and the sequential multiplier.
package alu_pkg;

    localparam int ALU_W = 16;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD    = '{zx: 1'b0, nx: 1'b0, zy: 1'b0, ny: 1'b0, f: 1'b1, no: 1'b0};
    localparam alu_ctrl_t ALU_PASS_X = '{zx: 1'b0, nx: 1'b0, zy: 1'b1, ny: 1'b0, f: 1'b1, no: 1'b0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU with zero/negate controls on each input and on the output.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] x,
    input  logic [ALU_W-1:0] y,
    input  alu_ctrl_t        ctrl,
    output logic [ALU_W-1:0] out,
    output logic             zr,
    output logic             ng
);

    logic [ALU_W-1:0] x_z, x_n, y_z, y_n, res;

    always_comb begin
        x_z = ctrl.zx ? '0 : x;
        x_n = ctrl.nx ? ~x_z : x_z;
        y_z = ctrl.zy ? '0 : y;
        y_n = ctrl.ny ? ~y_z : y_z;
        // Carry out of the top bit is dropped by the 16-bit sum.
        res = ctrl.f ? (x_n + y_n) : (x_n & y_n);
        out = ctrl.no ? ~res : res;
        zr  = (out == '0);
        ng  = out[ALU_W-1];
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add 16x16 multiplier (low half of product) using the shared ALU as its adder.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             zr,
    output logic             ng
);

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;

    alu_ctrl_t        alu_ctrl;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zr, alu_ng;

    // Add the shifted multiplicand only when the current multiplier bit is set.
    always_comb begin
        alu_ctrl    = ALU_ADD;
        alu_ctrl.zy = ~mplier_q[0];
    end

    alu u_alu (
        .x    (acc_q),
        .y    (mcand_q),
        .ctrl (alu_ctrl),
        .out  (alu_out),
        .zr   (alu_zr),
        .ng   (alu_ng)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        zr_d      = zr_q;
        ng_d      = ng_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = a;
                    mplier_d = b;
                    cnt_d    = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                acc_d    = alu_out;
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'(ITER - 1)) begin
                    product_d = alu_out;
                    zr_d      = alu_zr;
                    ng_d      = alu_ng;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            zr_q      <= 1'b1;
            ng_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            zr_q      <= zr_d;
            ng_q      <= ng_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;
    assign zr      = zr_q;
    assign ng      = ng_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: stimulus pushes expected results, a monitor pops on done.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, zr, ng;
    logic [15:0] product;

    typedef struct {
        logic [15:0] prod;
        logic        zr;
        logic        ng;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    alu_mul_seq #(.WIDTH(16), .ITER(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zr      (zr),
        .ng      (ng)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals done.
    always @(negedge clk) begin
        if (busy && done) check("busy_and_done", 32'd1, 32'd0);
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("product", product, e.prod);
                check("zr", zr, e.zr);
                check("ng", ng, e.ng);
                check("done_cycle", cyc, e.due);
            end
        end
    end

    // Called #1 after an edge; start is accepted at the next edge.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                         input logic [15:0] p, input bit expect_result);
        exp_t e;
        start = 1'b1;
        a = ia;
        b = ib;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
        check("busy_after_start", busy, 1'b1);
        if (expect_result) begin
            e.prod = p;
            e.zr   = (p == 16'h0000);
            e.ng   = p[15];
            e.due  = cyc + 16;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_product", product, 16'h0000);
        check("rst_zr", zr, 1'b1);
        check("rst_ng", ng, 1'b0);

        // Basic, wrap/sign, zero result
        issue(16'h0003, 16'h0005, 16'h000F, 1);
        idle(8);
        check("busy_mid_run", busy, 1'b1);
        wait_done();
        idle(1);
        issue(16'hFFFF, 16'h0007, 16'hFFF9, 1);
        wait_done();
        idle(1);
        issue(16'h0100, 16'h0100, 16'h0000, 1);
        wait_done();
        idle(2);

        // Start during RUN is ignored
        issue(16'h0002, 16'h0003, 16'h0006, 1);
        idle(4);
        start = 1'b1; a = 16'h0009; b = 16'h0009;
        idle(1);
        start = 1'b0;
        wait_done();
        idle(20);
        check("no_second_op", busy, 1'b0);

        // Back-to-back: start issued in the DONE cycle
        issue(16'h0010, 16'h0010, 16'h0100, 1);
        wait_done();
        issue(16'h1234, 16'h0002, 16'h2468, 1);
        wait_done();
        idle(2);

        // Reset mid-run aborts
        issue(16'h00FF, 16'h00FF, 16'h0000, 0);
        idle(7);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_product", product, 16'h0000);
        check("abort_zr", zr, 1'b1);
        check("abort_ng", ng, 1'b0);
        idle(20);
        check("abort_still_idle", busy, 1'b0);
        issue(16'h00FF, 16'h00FF, 16'hFE01, 1);
        wait_done();
        idle(3);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
